// File: rtl/furv_pkg.sv
// Shared RV32I decode types for the ALU issue stage: opcodes, result select
// encoding and the packed micro-op handed from decode to the issue buffer.
package furv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    RES_ARITH  = 2'd0,
    RES_LOGIC  = 2'd1,
    RES_CMP    = 2'd2,
    RES_BRANCH = 2'd3
  } res_sel_e;

  typedef struct packed {
    logic [XLEN-1:0] ra;
    logic [XLEN-1:0] rb;
    logic [XLEN-1:0] rca;
    logic [XLEN-1:0] rcb;
    logic            arith_mode;
    logic            logic_alt;
    logic [2:0]      funct3;
    logic            lt;
    logic            invert_comparison;
    logic            unsigned_comparison;
    res_sel_e        res_sel;
    logic [4:0]      rd;
    logic            illegal;
  } alu_uop_t;

  // OP and OP-IMM share the same funct3 -> result unit mapping.
  function automatic res_sel_e alu_res_sel(input logic [2:0] f3);
    if (f3 == 3'b000)
      return RES_ARITH;
    else if (f3[2:1] == 2'b01)
      return RES_CMP;
    else
      return RES_LOGIC;
  endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational RV32I decoder: turns one instruction plus its operands into
// the ALU micro-op. Unsupported opcodes yield an all-zero op with illegal set.
module alu_issue_dec
  import furv_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output alu_uop_t    uop
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  f3;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] imm_b;
  logic [31:0] imm_op;
  logic        is_cmp;
  logic        is_shift;

  assign opcode   = instr[6:0];
  assign funct7   = instr[31:25];
  assign f3       = instr[14:12];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_u    = {instr[31:12], 12'b0};
  assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign is_cmp   = (f3[2:1] == 2'b01);
  assign is_shift = (f3[1:0] == 2'b01);

  // Shift immediates carry only the shamt; the funct7 bits above it are opcode space.
  assign imm_op = is_shift ? {27'b0, instr[24:20]} : imm_i;

  always_comb begin
    uop = '0;
    case (opcode)
      OPC_OP: begin
        uop.ra                  = rs1_data;
        uop.rb                  = rs2_data;
        uop.rca                 = rs1_data;
        uop.rcb                 = rs2_data;
        uop.funct3              = f3;
        uop.logic_alt           = instr[30];
        uop.arith_mode          = (f3 == 3'b000) & instr[30];
        uop.res_sel             = alu_res_sel(f3);
        uop.lt                  = is_cmp;
        uop.unsigned_comparison = is_cmp & f3[0];
        uop.rd                  = instr[11:7];
        uop.illegal             = !((funct7 == 7'b0000000) ||
                                    (funct7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        uop.ra                  = rs1_data;
        uop.rb                  = imm_op;
        uop.rca                 = rs1_data;
        uop.rcb                 = imm_op;
        uop.funct3              = f3;
        uop.logic_alt           = (f3 == 3'b101) & instr[30];
        uop.res_sel             = alu_res_sel(f3);
        uop.lt                  = is_cmp;
        uop.unsigned_comparison = is_cmp & f3[0];
        uop.rd                  = instr[11:7];
        uop.illegal             = ((f3 == 3'b001) && (funct7 != 7'b0000000)) ||
                                  ((f3 == 3'b101) && (funct7 != 7'b0000000) &&
                                   (funct7 != 7'b0100000));
      end
      OPC_LUI: begin
        uop.rb      = imm_u;
        uop.res_sel = RES_ARITH;
        uop.rd      = instr[11:7];
      end
      OPC_AUIPC: begin
        uop.ra      = pc;
        uop.rb      = imm_u;
        uop.res_sel = RES_ARITH;
        uop.rd      = instr[11:7];
      end
      OPC_BRANCH: begin
        uop.ra                  = pc;
        uop.rb                  = imm_b;
        uop.rca                 = rs1_data;
        uop.rcb                 = rs2_data;
        uop.funct3              = f3;
        uop.lt                  = f3[2];
        uop.invert_comparison   = f3[0];
        uop.unsigned_comparison = f3[1];
        uop.res_sel             = RES_BRANCH;
        uop.illegal             = (f3[2:1] == 2'b01);
      end
      default: uop.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes one instruction per cycle and holds the micro-op in
// an output register backed by a skid register so backpressure loses nothing.
module alu_issue
  import furv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ra,
  output logic [XLEN-1:0] rb,
  output logic [XLEN-1:0] rca,
  output logic [XLEN-1:0] rcb,
  output logic            arith_mode,
  output logic            logic_alt,
  output logic [2:0]      funct3,
  output logic            lt,
  output logic            invert_comparison,
  output logic            unsigned_comparison,
  output logic [1:0]      res_sel,
  output logic [4:0]      rd,
  output logic            illegal
);

  alu_uop_t dec_uop;
  alu_uop_t out_uop;
  alu_uop_t skid_uop;
  logic     out_vld;
  logic     skid_vld;
  logic     accept;
  logic     issue;

  alu_issue_dec u_dec (
    .instr    (instr),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .uop      (dec_uop)
  );

  // in_ready comes straight from a flop: the stage stops accepting only once the skid is used.
  assign in_ready = !skid_vld;
  assign accept   = in_valid && in_ready;
  assign issue    = out_vld && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      out_uop  <= '0;
      skid_uop <= '0;
    end else if (flush) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      out_uop  <= '0;
      skid_uop <= '0;
    end else if (!out_vld || issue) begin
      if (skid_vld) begin
        out_uop  <= skid_uop;
        skid_vld <= 1'b0;
        skid_uop <= '0;
      end else if (accept) begin
        out_uop <= dec_uop;
        out_vld <= 1'b1;
      end else begin
        out_uop <= '0;
        out_vld <= 1'b0;
      end
    end else if (accept) begin
      skid_uop <= dec_uop;
      skid_vld <= 1'b1;
    end
  end

  assign out_valid           = out_vld;
  assign ra                  = out_uop.ra;
  assign rb                  = out_uop.rb;
  assign rca                 = out_uop.rca;
  assign rcb                 = out_uop.rcb;
  assign arith_mode          = out_uop.arith_mode;
  assign logic_alt           = out_uop.logic_alt;
  assign funct3              = out_uop.funct3;
  assign lt                  = out_uop.lt;
  assign invert_comparison   = out_uop.invert_comparison;
  assign unsigned_comparison = out_uop.unsigned_comparison;
  assign res_sel             = out_uop.res_sel;
  assign rd                  = out_uop.rd;
  assign illegal             = out_uop.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: hand-coded decode vectors, backpressure/flush/reset
// sequences and a randomized run against a queue-based reference model.
module tb_alu_issue;
  import furv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ra, rb, rca, rcb;
  logic        arith_mode, logic_alt, lt, invert_comparison, unsigned_comparison, illegal;
  logic [2:0]  funct3;
  logic [1:0]  res_sel;
  logic [4:0]  rd;

  int passed = 0;
  int total  = 0;
  alu_uop_t q[$];

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    alu_uop_t    exp;
  } vec_t;

  vec_t vecs[10];

  alu_issue #(.XLEN(32)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .flush               (flush),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .instr               (instr),
    .pc                  (pc),
    .rs1_data            (rs1_data),
    .rs2_data            (rs2_data),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .ra                  (ra),
    .rb                  (rb),
    .rca                 (rca),
    .rcb                 (rcb),
    .arith_mode          (arith_mode),
    .logic_alt           (logic_alt),
    .funct3              (funct3),
    .lt                  (lt),
    .invert_comparison   (invert_comparison),
    .unsigned_comparison (unsigned_comparison),
    .res_sel             (res_sel),
    .rd                  (rd),
    .illegal             (illegal)
  );

  always #5 clk = ~clk;

  function automatic alu_uop_t mk(input logic [31:0] a, b, ca, cb, input logic am, la,
                                  input logic [2:0] f, input logic l, inv, uns,
                                  input res_sel_e rs, input logic [4:0] d, input logic ill);
    alu_uop_t u;
    u.ra = a; u.rb = b; u.rca = ca; u.rcb = cb;
    u.arith_mode = am; u.logic_alt = la; u.funct3 = f;
    u.lt = l; u.invert_comparison = inv; u.unsigned_comparison = uns;
    u.res_sel = rs; u.rd = d; u.illegal = ill;
    return u;
  endfunction

  function automatic alu_uop_t dut_uop();
    return mk(ra, rb, rca, rcb, arith_mode, logic_alt, funct3, lt, invert_comparison,
              unsigned_comparison, res_sel_e'(res_sel), rd, illegal);
  endfunction

  // Reference decode written from the ISA rules with signed arithmetic.
  function automatic alu_uop_t ref_decode(input logic [31:0] i, p, a, b);
    alu_uop_t    u;
    logic [2:0]  f = i[14:12];
    logic [6:0]  f7 = i[31:25];
    logic [12:0] boff = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    logic [31:0] ii = int'($signed(i[31:20]));
    logic [31:0] bi = int'($signed(boff));
    logic [31:0] ui = i[31:12] * 32'h1000;
    logic        cmp = (f == 3'd2) || (f == 3'd3);
    u = '0;
    if (i[6:0] == 7'h33 || i[6:0] == 7'h13) begin
      u.ra = a; u.rca = a; u.rd = i[11:7]; u.funct3 = f;
      u.res_sel = (f == 3'd0) ? RES_ARITH : (cmp ? RES_CMP : RES_LOGIC);
      u.lt = cmp; u.unsigned_comparison = cmp && f == 3'd3;
      if (i[6:0] == 7'h33) begin
        u.rb = b; u.rcb = b;
        u.logic_alt = i[30];
        u.arith_mode = (f == 3'd0) && i[30];
        u.illegal = !(f7 == 7'd0 || (f7 == 7'd32 && (f == 3'd0 || f == 3'd5)));
      end else begin
        u.rb = (f == 3'd1 || f == 3'd5) ? 32'(i[24:20]) : ii;
        u.rcb = u.rb;
        u.logic_alt = (f == 3'd5) && i[30];
        u.illegal = (f == 3'd1 && f7 != 7'd0) || (f == 3'd5 && f7 != 7'd0 && f7 != 7'd32);
      end
    end else if (i[6:0] == 7'h37 || i[6:0] == 7'h17) begin
      u.ra = (i[6:0] == 7'h17) ? p : 32'd0;
      u.rb = ui; u.res_sel = RES_ARITH; u.rd = i[11:7];
    end else if (i[6:0] == 7'h63) begin
      u.ra = p; u.rb = bi; u.rca = a; u.rcb = b; u.funct3 = f;
      u.lt = (f >= 3'd4); u.invert_comparison = (f % 2 == 1);
      u.unsigned_comparison = (f == 3'd6 || f == 3'd7 || f == 3'd2 || f == 3'd3);
      u.res_sel = RES_BRANCH; u.illegal = cmp;
    end else begin
      u.illegal = 1'b1;
    end
    return u;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r = $urandom;
    logic [2:0]  f = r[14:12];
    case ($urandom_range(0, 6))
      0: begin
        r[6:0] = 7'h33;
        r[31:25] = (($urandom_range(0, 1) == 1) && (f == 3'd0 || f == 3'd5)) ? 7'h20 : 7'h00;
      end
      1: begin
        r[6:0] = 7'h13;
        if (f == 3'd1) r[31:25] = 7'h00;
        else if (f == 3'd5) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end
      2: r[6:0] = 7'h37;
      3: r[6:0] = 7'h17;
      4: begin
        r[6:0] = 7'h63;
        if (f == 3'd2 || f == 3'd3) r[14:12] = 3'd4;
      end
      5: begin
        if (r[6:0] == 7'h33 || r[6:0] == 7'h13 || r[6:0] == 7'h37 ||
            r[6:0] == 7'h17 || r[6:0] == 7'h63)
          r[6:0] = 7'h0F;
      end
      default: r[6:0] = ($urandom_range(0, 1) == 1) ? 7'h33 : 7'h13;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp)
      $display("[TB] FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    else
      passed++;
  endtask

  // One cycle: drive inputs after the falling edge, check, then advance the model at the rising edge.
  task automatic applyStimulus(input logic iv, input logic [31:0] ins, p, a, b,
                               input logic ordy, fl, input alu_uop_t exp);
    logic acc, iss;
    in_valid = iv; instr = ins; pc = p; rs1_data = a; rs2_data = b;
    out_ready = ordy; flush = fl;
    #1;
    checkOutput("in_ready", 160'(in_ready), 160'(q.size() < 2));
    checkOutput("out_valid", 160'(out_valid), 160'(q.size() > 0));
    if (q.size() > 0) checkOutput("uop", 160'(dut_uop()), 160'(q[0]));
    acc = iv && (q.size() < 2);
    iss = ordy && (q.size() > 0);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (iss) void'(q.pop_front());
      if (acc) q.push_back(exp);
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, ordy, 1'b0, '0);
  endtask

  task automatic applyVec(input int k, input logic ordy, input logic fl);
    applyStimulus(1'b1, vecs[k].instr, vecs[k].pc, vecs[k].rs1, vecs[k].rs2, ordy, fl, vecs[k].exp);
  endtask

  task automatic applyRef(input logic [31:0] ins, input logic ordy);
    logic [31:0] p = $urandom, a = $urandom, b = $urandom;
    applyStimulus(1'b1, ins, p, a, b, ordy, 1'b0, ref_decode(ins, p, a, b));
  endtask

  initial begin
    vecs[0] = '{32'h002081B3, 32'h0, 32'd5, 32'd7,
                mk(32'd5, 32'd7, 32'd5, 32'd7, 0, 0, 3'd0, 0, 0, 0, RES_ARITH, 5'd3, 0)};
    vecs[1] = '{32'h402081B3, 32'h0, 32'd9, 32'd4,
                mk(32'd9, 32'd4, 32'd9, 32'd4, 1, 1, 3'd0, 0, 0, 0, RES_ARITH, 5'd3, 0)};
    vecs[2] = '{32'h4030D213, 32'h0, 32'h80000000, 32'd1,
                mk(32'h80000000, 32'd3, 32'h80000000, 32'd3, 0, 1, 3'd5, 0, 0, 0, RES_LOGIC, 5'd4, 0)};
    vecs[3] = '{32'h0020E463, 32'h100, 32'd1, 32'hFFFFFFFF,
                mk(32'h100, 32'd8, 32'd1, 32'hFFFFFFFF, 0, 0, 3'd6, 1, 0, 1, RES_BRANCH, 5'd0, 0)};
    vecs[4] = '{32'h0000007F, 32'h44, 32'd3, 32'd4,
                mk(32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 3'd0, 0, 0, 0, RES_ARITH, 5'd0, 1)};
    vecs[5] = '{32'h123452B7, 32'h0, 32'd11, 32'd12,
                mk(32'd0, 32'h12345000, 32'd0, 32'd0, 0, 0, 3'd0, 0, 0, 0, RES_ARITH, 5'd5, 0)};
    vecs[6] = '{32'hFFFFF317, 32'h200, 32'd1, 32'd2,
                mk(32'h200, 32'hFFFFF000, 32'd0, 32'd0, 0, 0, 3'd0, 0, 0, 0, RES_ARITH, 5'd6, 0)};
    vecs[7] = '{32'hFFF0B393, 32'h0, 32'd5, 32'd6,
                mk(32'd5, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 0, 0, 3'd3, 1, 0, 1, RES_CMP, 5'd7, 0)};
    vecs[8] = '{32'hFE20DEE3, 32'h300, 32'hFFFFFFF0, 32'd2,
                mk(32'h300, 32'hFFFFFFFC, 32'hFFFFFFF0, 32'd2, 0, 0, 3'd5, 1, 1, 0, RES_BRANCH, 5'd0, 0)};
    vecs[9] = '{32'h80008413, 32'h0, 32'h10, 32'd0,
                mk(32'h10, 32'hFFFFF800, 32'h10, 32'hFFFFF800, 0, 0, 3'd0, 0, 0, 0, RES_ARITH, 5'd8, 0)};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    #2;
    checkOutput("reset_out_valid", 160'(out_valid), 160'(0));
    checkOutput("reset_in_ready", 160'(in_ready), 160'(1));
    checkOutput("reset_fields", 160'(dut_uop()), 160'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed decode vectors, back to back with the consumer always ready.
    for (int k = 0; k < 10; k++) applyVec(k, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Illegal funct encodings on otherwise supported opcodes.
    applyRef(32'h022081B3, 1'b1);
    applyRef(32'h402091B3, 1'b1);
    applyRef(32'h40309213, 1'b1);
    applyRef(32'h0020A063, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Backpressure: three offered while stalled; only two fit, order preserved.
    applyVec(0, 1'b0, 1'b0);
    applyVec(1, 1'b0, 1'b0);
    applyVec(2, 1'b0, 1'b0);
    checkOutput("bp_in_ready_full", 160'(in_ready), 160'(0));
    applyVec(2, 1'b1, 1'b0);
    applyVec(2, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) idle(1'b1);

    // Flush with both entries full while a third is offered.
    applyVec(3, 1'b0, 1'b0);
    applyVec(5, 1'b0, 1'b0);
    applyVec(6, 1'b1, 1'b1);
    checkOutput("flush_out_valid", 160'(out_valid), 160'(0));
    checkOutput("flush_in_ready", 160'(in_ready), 160'(1));
    idle(1'b1);

    // Flush overriding a simultaneous accept and issue.
    applyVec(7, 1'b0, 1'b0);
    applyVec(8, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 600; k++) begin
      logic [31:0] ins = gen_instr();
      logic [31:0] p = $urandom, a = $urandom, b = $urandom;
      applyStimulus($urandom_range(0, 3) != 0, ins, p, a, b, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 40) == 0, ref_decode(ins, p, a, b));
    end
    for (int k = 0; k < 4; k++) idle(1'b1);

    // Asynchronous reset in the middle of a cycle with a valid op held.
    applyVec(4, 1'b0, 1'b0);
    applyVec(9, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 160'(out_valid), 160'(0));
    checkOutput("midreset_in_ready", 160'(in_ready), 160'(1));
    checkOutput("midreset_fields", 160'(dut_uop()), 160'(0));
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Illegal opcode after reset recovery.
    applyVec(4, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
